// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the 4096x16 main memory: one access per IDLE->ACC->ACK pass, request-to-ack 2 clocks.
// Backpressure: requesters hold req until their ack pulse; the loser simply waits, a locked winner keeps the next grant.
module mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] mem_rdata,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic          lock_q, lock_d;
  logic          last_gnt_q, last_gnt_d;
  logic          after_ack_q, after_ack_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          lock_hit;
  logic          win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      last_gnt_q  <= 1'b1;
      after_ack_q <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      lock_q      <= lock_d;
      last_gnt_q  <= last_gnt_d;
      after_ack_q <= after_ack_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // A lock only holds for the single IDLE cycle right after the locked access's ACK.
  always_comb begin
    lock_hit = 1'b0;
    win      = 1'b0;
    if (after_ack_q && lock_q) begin
      lock_hit = last_gnt_q ? req1 : req0;
    end
    if (lock_hit) begin
      win = last_gnt_q;
    end else if (FIXED_PRI != 0) begin
      win = !req0;
    end else if (req0 && req1) begin
      win = !last_gnt_q;
    end else begin
      win = req1;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    lock_d      = lock_q;
    last_gnt_d  = last_gnt_q;
    after_ack_d = 1'b0;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          we_d       = win ? we1    : we0;
          lock_d     = win ? lock1  : lock0;
          adr_d      = win ? adr1   : adr0;
          wdata_d    = win ? wdata1 : wdata0;
          last_gnt_d = win;
          state_d    = ACC;
        end
      end
      ACC: begin
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        state_d = ACK;
      end
      ACK: begin
        after_ack_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory pins decode from registered state only, so reset drops them at once.
  assign mem_read  = (state_q == ACC) && !we_q;
  assign mem_write = (state_q == ACC) && we_q;
  assign mem_adr   = (state_q == ACC) ? adr_q   : '0;
  assign mem_wdata = (state_q == ACC) ? wdata_q : '0;

  assign ack0  = (state_q == ACK) && !last_gnt_q;
  assign ack1  = (state_q == ACK) && last_gnt_q;
  assign busy  = (state_q == ACC) || (state_q == ACK);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (u_rr) and fixed-priority instance (u_fx) share stimulus, each with its own memory model.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] adr0, adr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          a_ack0, a_ack1, a_busy, a_rd, a_wr;
  logic [DW-1:0] a_rdata, a_wdata, a_mrdata;
  logic [AW-1:0] a_adr;
  logic          b_ack0, b_ack1, b_busy, b_rd, b_wr;
  logic [DW-1:0] b_rdata, b_wdata, b_mrdata;
  logic [AW-1:0] b_adr;

  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  logic          pl_en;
  logic [AW-1:0] pl_adr;
  logic [DW-1:0] pl_dat;

  int n_chk = 0;
  int n_err = 0;
  int a_ack0_cnt = 0;
  int saved_cnt;
  logic p;

  mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(a_mrdata), .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .busy(a_busy),
    .mem_read(a_rd), .mem_write(a_wr), .mem_adr(a_adr), .mem_wdata(a_wdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(b_mrdata), .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
    .mem_read(b_rd), .mem_write(b_wr), .mem_adr(b_adr), .mem_wdata(b_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_mrdata = mem_a[a_adr];
  assign b_mrdata = mem_b[b_adr];

  always @(posedge clk) begin
    if (pl_en) begin
      mem_a[pl_adr] <= pl_dat;
      mem_b[pl_adr] <= pl_dat;
    end else begin
      if (a_wr) mem_a[a_adr] <= a_wdata;
      if (b_wr) mem_b[b_adr] <= b_wdata;
    end
  end

  always @(posedge clk) if (a_ack0) a_ack0_cnt <= a_ack0_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nc;
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    pl_adr = adr;
    pl_dat = dat;
    pl_en  = 1'b1;
    nc();
    pl_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {req0, req1, we0, we1, lock0, lock1} = '0;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
    pl_en = 1'b0; pl_adr = '0; pl_dat = '0;
    nc();
    preload(12'h064, 16'h7800);
    preload(12'h0C8, 16'h1100);

    chk("rst_ack0", a_ack0, 0);
    chk("rst_ack1", a_ack1, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_wr", a_wr, 0);
    chk("rst_adr", a_adr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_fx_busy", b_busy, 0);
    rst_n = 1'b1;
    nc();
    chk("idle_busy", a_busy, 0);

    // single read from port 0
    req0 = 1'b1; we0 = 1'b0; adr0 = 12'h064;
    nc();
    chk("rd_mem_read", a_rd, 1);
    chk("rd_mem_write", a_wr, 0);
    chk("rd_mem_adr", a_adr, 12'h064);
    chk("rd_busy", a_busy, 1);
    chk("rd_early_ack", a_ack0, 0);
    nc();
    chk("rd_ack0", a_ack0, 1);
    chk("rd_ack1", a_ack1, 0);
    chk("rd_rdata", a_rdata, 16'h7800);
    chk("rd_ack_mem_read", a_rd, 0);
    chk("rd_ack_adr", a_adr, 0);
    chk("rd_fx_rdata", b_rdata, 16'h7800);
    req0 = 1'b0;
    nc();
    chk("rd_ack_pulse", a_ack0, 0);
    chk("rd_busy_end", a_busy, 0);

    // port 1 write then back-to-back read
    saved_cnt = a_ack0_cnt;
    req1 = 1'b1; we1 = 1'b1; adr1 = 12'h190; wdata1 = 16'hA5C3;
    nc();
    chk("wr_mem_write", a_wr, 1);
    chk("wr_mem_read", a_rd, 0);
    chk("wr_mem_adr", a_adr, 12'h190);
    chk("wr_mem_wdata", a_wdata, 16'hA5C3);
    nc();
    chk("wr_ack1", a_ack1, 1);
    chk("wr_write_off", a_wr, 0);
    chk("wr_rdata_kept", a_rdata, 16'h7800);
    we1 = 1'b0; wdata1 = '0;
    nc();
    chk("wr_idle_busy", a_busy, 0);
    nc();
    chk("wr_rb_read", a_rd, 1);
    chk("wr_rb_adr", a_adr, 12'h190);
    nc();
    chk("wr_rb_ack1", a_ack1, 1);
    chk("wr_rb_rdata", a_rdata, 16'hA5C3);
    req1 = 1'b0;
    nc();
    chk("wr_no_ack0", a_ack0_cnt, saved_cnt);

    // locked read-modify-write on port 0 with port 1 contending
    preload(12'h190, 16'h0005);
    req0 = 1'b1; we0 = 1'b0; adr0 = 12'h190; lock0 = 1'b1;
    req1 = 1'b1; we1 = 1'b0; adr1 = 12'h190;
    nc();
    chk("lk_rd_read", a_rd, 1);
    nc();
    chk("lk_rd_ack0", a_ack0, 1);
    chk("lk_rd_ack1", a_ack1, 0);
    chk("lk_rd_rdata", a_rdata, 16'h0005);
    we0 = 1'b1; wdata0 = 16'h0006; lock0 = 1'b0;
    nc();
    nc();
    chk("lk_wr_write", a_wr, 1);
    chk("lk_wr_wdata", a_wdata, 16'h0006);
    nc();
    chk("lk_wr_ack0", a_ack0, 1);
    chk("lk_wr_ack1", a_ack1, 0);
    req0 = 1'b0; we0 = 1'b0;
    nc();
    nc();
    chk("lk_p1_read", a_rd, 1);
    nc();
    chk("lk_p1_ack1", a_ack1, 1);
    chk("lk_p1_rdata", a_rdata, 16'h0006);
    chk("lk_fx_rdata", b_rdata, 16'h0006);
    req1 = 1'b0;
    nc();

    // sustained contention: u_rr alternates starting at port 0, u_fx always serves port 0
    req0 = 1'b1; adr0 = 12'h200;
    req1 = 1'b1; adr1 = 12'h300;
    for (int i = 0; i < 4; i++) begin
      p = i[0];
      nc();
      chk("ct_rr_adr", a_adr, p ? adr1 : adr0);
      chk("ct_fx_adr", b_adr, adr0);
      nc();
      chk("ct_rr_ack0", a_ack0, !p);
      chk("ct_rr_ack1", a_ack1, p);
      chk("ct_fx_ack0", b_ack0, 1);
      chk("ct_fx_ack1", b_ack1, 0);
      if (p) adr1 = adr1 + 1'b1;
      else   adr0 = adr0 + 1'b1;
      nc();
      chk("ct_gap", a_ack0 | a_ack1, 0);
    end
    req0 = 1'b0;
    nc();
    nc();
    chk("ct_fx_p1_ack1", b_ack1, 1);
    chk("ct_fx_p1_ack0", b_ack0, 0);
    chk("ct_rr_p1_ack1", a_ack1, 1);
    req1 = 1'b0;
    nc();

    // reset during an ACC write
    saved_cnt = a_ack0_cnt;
    req0 = 1'b1; we0 = 1'b1; adr0 = 12'h0C8; wdata0 = 16'hBEEF;
    nc();
    chk("rs_write_on", a_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_write_drop", a_wr, 0);
    chk("rs_fx_write_drop", b_wr, 0);
    chk("rs_busy", a_busy, 0);
    chk("rs_adr", a_adr, 0);
    req0 = 1'b0; we0 = 1'b0;
    nc();
    chk("rs_ack0", a_ack0, 0);
    chk("rs_rdata", a_rdata, 0);
    chk("rs_wdata", a_wdata, 0);
    chk("rs_rd", a_rd, 0);
    chk("rs_mem_kept", mem_a[12'h0C8], 16'h1100);
    rst_n = 1'b1;
    req0 = 1'b1; adr0 = 12'h064;
    req1 = 1'b1; adr1 = 12'h190;
    nc();
    chk("rs_tie_adr", a_adr, 12'h064);
    chk("rs_tie_read", a_rd, 1);
    nc();
    chk("rs_tie_ack0", a_ack0, 1);
    chk("rs_tie_ack1", a_ack1, 0);
    chk("rs_tie_rdata", a_rdata, 16'h7800);
    chk("rs_no_abort_ack", a_ack0_cnt, saved_cnt);
    req0 = 1'b0; req1 = 1'b0;
    nc();
    nc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
